// File: rtl/axi_word_unpack_if.sv
// Handshake bundle between the AXI read-data source, the word unpacker and the
// nibble serialiser.
interface axi_word_unpack_if #(
  parameter int WORD_WIDTH = 32,
  parameter int NIB_WIDTH  = 4
);
  logic                  start;
  logic [WORD_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [NIB_WIDTH-1:0]  nib_data;
  logic                  nib_valid;
  logic                  pts_ready;
  logic                  busy;
  logic                  img_done;

  modport master (
    output start, s_data, s_valid, pts_ready,
    input  s_ready, nib_data, nib_valid, busy, img_done
  );

  modport slave (
    input  start, s_data, s_valid, pts_ready,
    output s_ready, nib_data, nib_valid, busy, img_done
  );
endinterface

// File: rtl/axi_word_unpack.sv
// Buffers AXI read-data words in a small FIFO and hands them to the serialiser
// one nibble at a time, lowest nibble first, for exactly one image per start.
module axi_word_unpack #(
  parameter int WORD_WIDTH  = 32,
  parameter int NIB_WIDTH   = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int NIB_PER_IMG = 3136
) (
  input  logic               CLK,
  input  logic               RST,
  axi_word_unpack_if.slave   bus
);
  localparam int NPW   = WORD_WIDTH / NIB_WIDTH;
  localparam int WORDS = NIB_PER_IMG / NPW;
  localparam int WCW   = $clog2(WORDS + 1);
  localparam int NCW   = $clog2(NIB_PER_IMG + 1);
  localparam int IW    = $clog2(NPW);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  localparam logic [WCW-1:0] WORDS_W   = WCW'(WORDS);
  localparam logic [NCW-1:0] NIB_LAST  = NCW'(NIB_PER_IMG - 1);
  localparam logic [IW-1:0]  IDX_LAST  = IW'(NPW - 1);
  localparam logic [CW-1:0]  FIFO_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [WCW-1:0]        word_cnt_q, word_cnt_d;
  logic [NCW-1:0]        nib_cnt_q, nib_cnt_d;
  logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         fifo_cnt_q, fifo_cnt_d;
  logic [WORD_WIDTH-1:0] unpack_q, unpack_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  loaded_q, loaded_d;

  logic                  s_ready_s;
  logic                  nib_valid_s;
  logic                  push_s;
  logic                  xfer_s;
  logic                  pop_s;
  logic [NPW-1:0][NIB_WIDTH-1:0] nibs_s;

  // Handshake qualifiers; s_ready depends on registered state only.
  assign s_ready_s   = (state_q == ST_RUN) && (fifo_cnt_q != FIFO_FULL) && (word_cnt_q < WORDS_W);
  assign nib_valid_s = loaded_q && (state_q == ST_RUN);
  assign push_s      = bus.s_valid && s_ready_s;
  assign xfer_s      = nib_valid_s && bus.pts_ready;
  // Refill the unpack register when empty, or in the same cycle its last nibble leaves.
  assign pop_s       = (state_q == ST_RUN) && (fifo_cnt_q != '0) &&
                       (!loaded_q || (xfer_s && (idx_q == IDX_LAST)));
  assign nibs_s      = unpack_q;

  assign bus.s_ready   = s_ready_s;
  assign bus.nib_valid = nib_valid_s;
  assign bus.nib_data  = nib_valid_s ? nibs_s[idx_q] : '0;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.img_done  = (state_q == ST_DONE);

  // Next-state, FIFO, counter and unpack-register update.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    nib_cnt_d  = nib_cnt_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    unpack_d   = unpack_q;
    idx_d      = idx_q;
    loaded_d   = loaded_q;

    if (push_s) begin
      mem_d[wr_ptr_q] = bus.s_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
      word_cnt_d      = word_cnt_q + WCW'(1);
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      unpack_d = mem_q[rd_ptr_q];
      idx_d    = '0;
      loaded_d = 1'b1;
    end else if (xfer_s && (idx_q == IDX_LAST)) begin
      loaded_d = 1'b0;
    end else if (xfer_s) begin
      idx_d    = idx_q + IW'(1);
    end else begin
      loaded_d = loaded_q;
    end

    case ({push_s, pop_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (xfer_s) begin
      nib_cnt_d = nib_cnt_q + NCW'(1);
    end else begin
      nib_cnt_d = nib_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_RUN;
          word_cnt_d = '0;
          nib_cnt_d  = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          fifo_cnt_d = '0;
          idx_d      = '0;
          loaded_d   = 1'b0;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (xfer_s && (nib_cnt_q == NIB_LAST)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      nib_cnt_q  <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      unpack_q   <= '0;
      idx_q      <= '0;
      loaded_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      nib_cnt_q  <= nib_cnt_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      unpack_q   <= unpack_d;
      idx_q      <= idx_d;
      loaded_q   <= loaded_d;
    end
  end
endmodule
